// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers and the status-flag bundle shared by the FIFO
// family (sync_fifo, async_fifo).
//   fifo_depth(addrsize) : number of entries, 1 << addrsize
//   fifo_cnt_w(addrsize) : occupancy counter width, addrsize + 1 (holds 0..DEPTH)
//   fifo_flags_t         : {full, empty, afull, aempty}
package fifo_pkg;

  function automatic int fifo_depth(input int addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic int fifo_cnt_w(input int addrsize);
    return addrsize + 32'd1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: dual-port storage for sync_fifo.
//   clk      in   clock
//   rst_n    in   async active-low reset (read register only; the array is not reset)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable; loads o_rdata on the next edge
//   i_raddr  in   read address
//   o_rdata  out  registered read data, holds its value when i_re is low
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [ADDRSIZE-1:0] i_waddr,
  input  logic [DATASIZE-1:0] i_wdata,
  input  logic                i_re,
  input  logic [ADDRSIZE-1:0] i_raddr,
  output logic [DATASIZE-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [DATASIZE-1:0] r_rdata;

  // Storage array write; deliberately unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; keeps the last word when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= {DATASIZE{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and a registered read port (1-cycle read latency).
// Optional feature: define SYNC_FIFO_ERR_EN to enable the sticky
// overflow/underflow flags; otherwise they are constant 0 and err_clr is ignored.
//   clk, rst_n        clock, async active-low reset
//   winc, wdata       write request / data (dropped while full)
//   rinc              read request (dropped while empty)
//   rdata, rvalid     read data; rvalid marks a read accepted on the previous edge
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AFULL_LEVEL
//   almost_empty      count <= AEMPTY_LEVEL
//   count             occupancy 0..DEPTH
//   err_clr           clears sticky error flags
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam int CNT_W = fifo_cnt_w(ADDRSIZE);

  localparam logic [CNT_W-1:0]  CNT_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AFULL  = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_AEMPTY = CNT_W'(AEMPTY_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDRSIZE:0] PTR_ONE    = (ADDRSIZE+1)'(1);

  logic [ADDRSIZE:0] r_wptr;
  logic [ADDRSIZE:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rvalid;
  logic              r_overflow;
  logic              r_underflow;

  fifo_flags_t       w_flags;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATASIZE-1:0] w_rdata;

  // Status flags decoded from the registered count only, so they never glitch
  // on pointer transitions.
  always_comb begin
    w_flags        = fifo_flags_t'(4'b0000);
    w_flags.full   = (r_count == CNT_DEPTH);
    w_flags.empty  = (r_count == CNT_ZERO);
    w_flags.afull  = (r_count >= CNT_AFULL);
    w_flags.aempty = (r_count <= CNT_AEMPTY);
  end

  // Acceptance uses the pre-edge flags: a simultaneous read does not make room
  // for a write when full, and a simultaneous write is not readable when empty.
  assign w_wr_en = winc && !w_flags.full;
  assign w_rd_en = rinc && !w_flags.empty;

  // Pointers wrap naturally; the MSB is the wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {(ADDRSIZE+1){1'b0}};
      r_rptr <= {(ADDRSIZE+1){1'b0}};
    end else begin
      r_wptr <= w_wr_en ? (r_wptr + PTR_ONE) : r_wptr;
      r_rptr <= w_rd_en ? (r_rptr + PTR_ONE) : r_rptr;
    end
  end

  // Occupancy count and read-valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= CNT_ZERO;
      r_rvalid <= 1'b0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_rvalid <= w_rd_en;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a new error in the same cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_flags.full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
      if (rinc && w_flags.empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;

  // Error reporting compiled out: flags held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end
  end
`endif

  sync_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[ADDRSIZE-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rptr[ADDRSIZE-1:0]),
    .o_rdata (w_rdata)
  );

  assign rdata        = w_rdata;
  assign rvalid       = r_rvalid;
  assign full         = w_flags.full;
  assign empty        = w_flags.empty;
  assign almost_full  = w_flags.afull;
  assign almost_empty = w_flags.aempty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with a queue-based reference model.
// Written words are pushed to the model queue; each read the model expects to be
// accepted pops the expected word, which is compared with rdata one cycle later.
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;
`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       err_clr;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];

  always #5 clk = ~clk;

  sync_fifo #(
    .DATASIZE     (8),
    .ADDRSIZE     (4),
    .AFULL_LEVEL  (AFL),
    .AEMPTY_LEVEL (AEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, "/count"},  32'(count),        32'(sz));
    chk({tag, "/full"},   32'(full),         32'(sz == DEPTH));
    chk({tag, "/empty"},  32'(empty),        32'(sz == 0));
    chk({tag, "/afull"},  32'(almost_full),  32'(sz >= AFL));
    chk({tag, "/aempty"}, 32'(almost_empty), 32'(sz <= AEL));
  endtask

  // One clock cycle of stimulus; returns with outputs settled 1 ns after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input string tag);
    int         sz;
    logic       wacc;
    logic       racc;
    logic [7:0] exp_d;
    sz    = model_q.size();
    winc  = w;
    wdata = d;
    rinc  = r;
    wacc  = w && (sz != DEPTH);
    racc  = r && (sz != 0);
    exp_d = 8'h00;
    if (racc) exp_d = model_q.pop_front();
    if (wacc) model_q.push_back(d);
    @(posedge clk);
    #1;
    chk({tag, "/rvalid"}, 32'(rvalid), 32'(racc));
    if (racc) chk({tag, "/rdata"}, 32'(rdata), 32'(exp_d));
    chk_flags(tag);
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    // 1: reset with requests active
    rst_n   = 1'b0;
    winc    = 1'b1;
    rinc    = 1'b1;
    err_clr = 1'b1;
    wdata   = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst/empty",  32'(empty),        32'(1));
    chk("rst/aempty", 32'(almost_empty), 32'(1));
    chk("rst/count",  32'(count),        32'(0));
    chk("rst/rvalid", 32'(rvalid),       32'(0));
    chk("rst/rdata",  32'(rdata),        32'(0));
    chk("rst/full",   32'(full),         32'(0));
    chk("rst/afull",  32'(almost_full),  32'(0));
    chk("rst/ovf",    32'(overflow),     32'(0));
    chk("rst/udf",    32'(underflow),    32'(0));
    winc    = 1'b0;
    rinc    = 1'b0;
    err_clr = 1'b0;
    #2 rst_n = 1'b1;

    // 2: fill then drain, in order
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

    // 3: full boundary
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, "fill2");
    cycle(1'b1, 8'hAA, 1'b1, "full_rw");
    cycle(1'b1, 8'hAB, 1'b0, "refill");
    cycle(1'b1, 8'hAC, 1'b0, "ovf_wr");
    chk("ovf_wr/overflow", 32'(overflow), 32'(ERR_EN));
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain2");

    // 4: empty boundary and error clear
    cycle(1'b1, 8'h55, 1'b1, "empty_rw");
    cycle(1'b0, 8'h00, 1'b1, "rd55");
    cycle(1'b0, 8'h00, 1'b1, "udf_rd");
    chk("udf_rd/underflow", 32'(underflow), 32'(ERR_EN));
    err_clr = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, "clr");
    err_clr = 1'b0;
    chk("clr/underflow", 32'(underflow), 32'(0));
    chk("clr/overflow",  32'(overflow),  32'(0));

    // 5: wrap with steady occupancy of 8
    for (int i = 0; i < 8; i++)  cycle(1'b1, 8'h80 + 8'(i), 1'b0, "pre_wrap");
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b1, "wrap");
    for (int i = 0; i < 8; i++)  cycle(1'b0, 8'h00, 1'b1, "post_wrap");

    // 6: reset in the middle of operation, off the clock edge
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    chk("midrst/empty",  32'(empty),  32'(1));
    chk("midrst/count",  32'(count),  32'(0));
    chk("midrst/rvalid", 32'(rvalid), 32'(0));
    chk("midrst/rdata",  32'(rdata),  32'(0));
    #2 rst_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, "post_rst_wr");
    cycle(1'b0, 8'h00, 1'b1, "post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
